// File: rtl/bus_master_if_pkg.sv
// bus_master_if_pkg: shared state and bus-level encodings for the xCPU bus initiator
package bus_master_if_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACCESS, S_WAIT, S_DONE} state_e;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic ASSERT_N = 1'b0;
  localparam logic DEASSERT_N = 1'b1;
endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: saturating wait-cycle counter flagging the last cycle before a bus error
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign expired_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: single-access xCPU bus initiator (arbitrate, strobe, wait for rdy_, return data)
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wr_data,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              bus_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);
  state_e state_q, state_d;
  logic req_n_q, req_n_d, as_n_q, as_n_d, rw_q, rw_d, done_q, done_d, err_q, err_d, expired;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  // counter is held clear outside WAIT, so it starts at 0 on every WAIT entry
  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q != S_WAIT),
    .en_i(state_q == S_WAIT),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    req_n_d = req_n_q;
    as_n_d = as_n_q;
    rw_d = rw_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_REQ;
        req_n_d = ASSERT_N;
        rw_d = req_rw;
        addr_d = req_addr;
        wdata_d = req_wr_data;
      end
      S_REQ: if (bus_grnt_ == ASSERT_N) begin
        state_d = S_ACCESS;
        as_n_d = ASSERT_N;
      end
      S_ACCESS, S_WAIT: begin
        as_n_d = DEASSERT_N;
        // a ready slave wins over an expiring counter
        if (bus_rdy_ == ASSERT_N) begin
          state_d = S_DONE;
          done_d = 1'b1;
          req_n_d = DEASSERT_N;
          if (rw_q != WRITE) rdata_d = bus_rd_data;
        end else if (state_q == S_ACCESS) begin
          state_d = S_WAIT;
        end else if (expired) begin
          state_d = S_DONE;
          done_d = 1'b1;
          err_d = 1'b1;
          req_n_d = DEASSERT_N;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_n_q <= DEASSERT_N;
      as_n_q <= DEASSERT_N;
      rw_q <= READ;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_n_q <= req_n_d;
      as_n_q <= as_n_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign stall = req_valid && state_q != S_DONE;
  assign done = done_q;
  assign bus_err = err_q;
  assign rd_data_out = rdata_q;
  assign bus_req_ = req_n_q;
  assign bus_as_ = as_n_q;
  assign bus_rw = rw_q;
  assign bus_addr = addr_q;
  assign bus_wr_data = wdata_q;
endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: randomized scoreboard bench with reactive arbiter/slave models
module tb_bus_master_if;
  localparam int T = 4;
  logic clk = 0, reset = 1, req_valid = 0, req_rw = 0;
  logic [29:0] req_addr = '0;
  logic [31:0] req_wr_data = '0;
  logic stall, done, bus_err, bus_req_, bus_as_, bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, rd_data_out;
  logic [31:0] bus_rd_data = '0;
  logic bus_grnt_ = 1, bus_rdy_ = 1;
  int total = 0, bad = 0, cyc = 0, cur_g = 0, cur_d = 0, as_cnt = 0, gcnt = 0, acnt = 0;
  bit active = 0;
  logic cur_rw = 1;
  logic [29:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0, cur_rdata = '0, last_rd = '0;
  typedef struct {logic err; logic [31:0] rd; int lat; int t0;} exp_t;
  exp_t sb[$];
  exp_t m_e;

  bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .stall(stall), .done(done), .rd_data_out(rd_data_out),
    .bus_err(bus_err), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // arbiter: grants after cur_g cycles of request; grant is noise while bus_req_ is high
  always @(posedge clk) begin
    #1;
    if (!bus_req_) begin
      if (gcnt == cur_g) bus_grnt_ = 0;
      else begin
        gcnt++;
        bus_grnt_ = 1;
      end
    end else begin
      gcnt = 0;
      bus_grnt_ = 1'($urandom);
    end
  end

  // slave: ready cur_d cycles after the strobe; rdy_/data are noise when no access is open
  always @(posedge clk) begin
    #1;
    if (!bus_as_) begin
      active = 1;
      acnt = 0;
      as_cnt++;
    end else if (active && !bus_req_) acnt++;
    else if (bus_req_) active = 0;
    bus_rdy_ = (active && acnt == cur_d) ? 1'b0 : (active ? 1'b1 : 1'($urandom));
    bus_rd_data = (active && acnt == cur_d) ? cur_rdata : $urandom;
    if (!bus_req_) begin
      chk("bus_addr", bus_addr, cur_addr);
      chk("bus_rw", bus_rw, cur_rw);
      chk("bus_wr_data", bus_wr_data, cur_wdata);
    end
  end

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 required no completion");
      end else begin
        m_e = sb.pop_front();
        chk("bus_err", bus_err, m_e.err);
        chk("rd_data_out", rd_data_out, m_e.rd);
        chk("latency", cyc - m_e.t0, m_e.lat);
        chk("req_released", bus_req_, 1);
        chk("as_cycles", as_cnt, 1);
      end
    end else chk("err_without_done", bus_err, 0);
  end

  task automatic run(input logic rw, input logic [29:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int g, input int d, input bit drop, input bit abort);
    exp_t e;
    @(negedge clk);
    cur_rw = rw; cur_addr = a; cur_wdata = wd; cur_rdata = rd; cur_g = g; cur_d = d; as_cnt = 0;
    req_valid = 1; req_rw = rw; req_addr = a; req_wr_data = wd;
    if (!abort) begin
      e.err = d > T;
      e.rd = (rw && d <= T) ? rd : last_rd;
      e.lat = 3 + g + (d > T ? T : d);
      e.t0 = cyc;
      last_rd = e.rd;
      sb.push_back(e);
    end
    for (int n = 0; ; n++) begin
      @(negedge clk);
      chk("stall", stall, req_valid && !done);
      if (done) break;
      if (abort && n == 3) begin
        reset = 1;
        @(negedge clk);
        chk("rst_bus_req_", bus_req_, 1);
        chk("rst_bus_as_", bus_as_, 1);
        chk("rst_done", done, 0);
        chk("rst_rd_data_out", rd_data_out, 0);
        reset = 0;
        last_rd = '0;
        break;
      end
      if (n >= 60) begin
        total++;
        bad++;
        $display("FAIL done_wait: got no done after %0d cycles required completion", n);
        break;
      end
      if (n == 0) begin
        req_addr = $urandom;
        req_wr_data = $urandom;
        req_rw = 1'($urandom);
        if (drop) req_valid = 0;
      end
    end
    req_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required bounded run");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_bus_req_", bus_req_, 1);
    chk("reset_bus_as_", bus_as_, 1);
    chk("reset_bus_rw", bus_rw, 1);
    chk("reset_bus_addr", bus_addr, 0);
    chk("reset_bus_wr_data", bus_wr_data, 0);
    chk("reset_rd_data_out", rd_data_out, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall, 0);
    reset = 0;
    run(1, 30'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    run(1, 30'h20, 32'h0, 32'hCAFEF00D, 0, 1, 0, 0);
    run(1, 30'h30, 32'h0, 32'h0BADF00D, 5, 1, 0, 0);
    run(0, 30'h3FF, 32'h12345678, 32'h55AA55AA, 0, 2, 0, 0);
    run(1, 30'h40, 32'h0, 32'h11111111, 0, 10, 0, 0);
    run(1, 30'h44, 32'h0, 32'h22222222, 0, T, 0, 0);
    run(1, 30'h48, 32'h0, 32'h33333333, 2, 1, 1, 0);
    run(1, 30'h50, 32'h0, 32'h44444444, 0, 20, 0, 1);
    run(1, 30'h54, 32'h0, 32'h66666666, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++)
      run(1'($urandom), 30'($urandom), $urandom, $urandom, $urandom_range(0, 4),
          $urandom_range(0, T + 2), $urandom_range(0, 7) == 0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
